bn_param_ctrl: RTL and testbench

Layer sequencer for the BN/residual stage. Per layer it loads the per-channel BN parameters `bn_a` and `bn_b` from a narrow streaming parameter bus into its output register banks. It then admits a programmed number of partial-sum pixels into the BN/residual datapath by generating that datapath's `data_in_valid`, and signals layer completion. It sits between the layer configuration/parameter fetch logic and the `bn_a`/`bn_b`/`data_in_valid` inputs of the BN/residual stage.

---
 rtl/bn_param_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bn_param_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_ctrl.sv
// bn_param_ctrl: per-layer sequencer for the BN/residual stage.
// It streams CHANNEL_NUM {a,b} parameter beats into the bn_a/bn_b banks.
// It then admits cfg_pix_num partial-sum pixels into the datapath and pulses layer_done.
module bn_param_ctrl #(
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int PIX_WIDTH   = 12
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   cfg_start,
    input  logic [PIX_WIDTH-1:0]                   cfg_pix_num,
    input  logic                                   para_valid,
    output logic                                   para_ready,
    input  logic [2*PARA_WIDTH-1:0]                para_data,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_a,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_b,
    input  logic                                   psum_valid,
    output logic                                   psum_ready,
    output logic                                   bn_data_in_valid,
    output logic                                   busy,
    output logic                                   layer_done,
    output logic                                   cfg_err
);

    localparam int CH_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                                 state_r;
    state_t                                 state_s;
    logic [CH_W-1:0]                        ch_cnt_r;
    logic [PIX_WIDTH-1:0]                   pix_cnt_r;
    logic [PIX_WIDTH-1:0]                   pix_num_r;
    logic                                   cfg_err_r;
    logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_a_r;
    logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_b_r;

    logic start_acc_s;
    logic start_err_s;
    logic beat_acc_s;
    logic beat_last_s;
    logic pix_acc_s;
    logic pix_last_s;

    // Next-state decode plus handshake qualifiers derived from state and counters
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        beat_acc_s  = 1'b0;
        beat_last_s = 1'b0;
        pix_acc_s   = 1'b0;
        pix_last_s  = 1'b0;
        start_err_s = cfg_start & (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    start_acc_s = 1'b1;
                    state_s     = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (para_valid) begin
                    beat_acc_s = 1'b1;
                    if (ch_cnt_r == CH_LAST) begin
                        beat_last_s = 1'b1;
                        // An empty layer skips RUN entirely
                        if (pix_num_r == {PIX_WIDTH{1'b0}}) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (psum_valid) begin
                    pix_acc_s = 1'b1;
                    if (pix_cnt_r == (pix_num_r - {{(PIX_WIDTH-1){1'b0}}, 1'b1})) begin
                        pix_last_s = 1'b1;
                        state_s    = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: purely from state, counters and the live psum_valid
    always_comb begin
        para_ready       = 1'b0;
        psum_ready       = 1'b0;
        bn_data_in_valid = 1'b0;
        layer_done       = 1'b0;
        busy             = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                para_ready = 1'b1;
            end
            ST_RUN: begin
                psum_ready       = 1'b1;
                bn_data_in_valid = psum_valid;
            end
            ST_DONE: begin
                layer_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign cfg_err = cfg_err_r;
    assign bn_a    = bn_a_r;
    assign bn_b    = bn_b_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Layer counters and latched pixel count; counters hold at their final value
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_cnt_r  <= {CH_W{1'b0}};
            pix_cnt_r <= {PIX_WIDTH{1'b0}};
            pix_num_r <= {PIX_WIDTH{1'b0}};
        end else if (start_acc_s) begin
            ch_cnt_r  <= {CH_W{1'b0}};
            pix_cnt_r <= {PIX_WIDTH{1'b0}};
            pix_num_r <= cfg_pix_num;
        end else begin
            if (beat_acc_s && !beat_last_s) begin
                ch_cnt_r <= ch_cnt_r + {{(CH_W-1){1'b0}}, 1'b1};
            end
            if (pix_acc_s && !pix_last_s) begin
                pix_cnt_r <= pix_cnt_r + {{(PIX_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sticky error: cfg_start seen while a layer is in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_err_r <= 1'b0;
        end else if (start_acc_s) begin
            cfg_err_r <= 1'b0;
        end else if (start_err_s) begin
            cfg_err_r <= 1'b1;
        end
    end

    // Parameter banks: one channel written per accepted beat, retained otherwise
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bn_a_r <= {(CHANNEL_NUM*PARA_WIDTH){1'b0}};
            bn_b_r <= {(CHANNEL_NUM*PARA_WIDTH){1'b0}};
        end else if (beat_acc_s) begin
            bn_a_r[ch_cnt_r] <= para_data[2*PARA_WIDTH-1:PARA_WIDTH];
            bn_b_r[ch_cnt_r] <= para_data[PARA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_bn_param_ctrl.sv
// Scoreboard bench for bn_param_ctrl: stimulus pushes expected pixel/done events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_bn_param_ctrl;
    localparam int PW = 16;
    localparam int CN = 128;
    localparam int XW = 12;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   cfg_start = 1'b0;
    logic [XW-1:0]          cfg_pix_num = '0;
    logic                   para_valid = 1'b0;
    logic                   para_ready;
    logic [2*PW-1:0]        para_data = '0;
    logic [CN-1:0][PW-1:0]  bn_a;
    logic [CN-1:0][PW-1:0]  bn_b;
    logic                   psum_valid = 1'b0;
    logic                   psum_ready;
    logic                   bn_data_in_valid;
    logic                   busy;
    logic                   layer_done;
    logic                   cfg_err;

    bn_param_ctrl #(.PARA_WIDTH(PW), .CHANNEL_NUM(CN), .PIX_WIDTH(XW)) dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_pix_num(cfg_pix_num),
        .para_valid(para_valid), .para_ready(para_ready), .para_data(para_data),
        .bn_a(bn_a), .bn_b(bn_b), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .bn_data_in_valid(bn_data_in_valid), .busy(busy), .layer_done(layer_done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;   // 0 = pixel admitted, 1 = layer_done
        int cyc;
        int ch;
        int a;
        int b;
    } exp_t;
    exp_t sbq[$];

    int exp_a[CN];
    int exp_b[CN];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int pa(input int seed, input int i);
        case (seed)
            0:       return i + 1;
            1:       return -7 * i - 2;
            default: return 3 * i - 200;
        endcase
    endfunction

    function automatic int pb(input int seed, input int i);
        case (seed)
            0:       return -i;
            1:       return 100 * i + 50;
            default: return 32767 - i;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented pixel or layer_done must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bn_data_in_valid || layer_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: valid=%0d done=%0d at cycle %0d, expected none",
                             bn_data_in_valid, layer_done, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind", layer_done ? 1 : 0, e.kind);
                    chk("event_cycle", cyc, e.cyc);
                    if (e.kind == 0) begin
                        chk($sformatf("run_bn_a[%0d]", e.ch), int'($signed(bn_a[e.ch])), e.a);
                        chk($sformatf("run_bn_b[%0d]", e.ch), int'($signed(bn_b[e.ch])), e.b);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_bank(input string tag);
        for (int i = 0; i < CN; i++) begin
            chk($sformatf("%s bn_a[%0d]", tag, i), int'($signed(bn_a[i])), exp_a[i]);
            chk($sformatf("%s bn_b[%0d]", tag, i), int'($signed(bn_b[i])), exp_b[i]);
        end
    endtask

    task automatic start_layer(input int pix, output int c0);
        cfg_pix_num = XW'(pix);
        cfg_start   = 1'b1;
        c0          = cyc;
        tick();
        cfg_start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cfg_err_clear", cfg_err, 0);
        chk("start_para_ready", para_ready, 1);
    endtask

    task automatic load(input int seed, input bit gaps, input bit poke);
        logic [PW-1:0] ta;
        logic [PW-1:0] tb;
        bit acc;
        int n;
        for (int i = 0; i < CN; i++) begin
            if (gaps && (i % 2 == 1)) begin
                para_valid = 1'b0;
                para_data  = 32'hDEAD_BEEF;
                psum_valid = 1'b1;
                tick();
                psum_valid = 1'b0;
            end
            ta = PW'(pa(seed, i));
            tb = PW'(pb(seed, i));
            para_valid = 1'b1;
            para_data  = {ta, tb};
            if (poke && i == 50) begin
                cfg_start   = 1'b1;
                cfg_pix_num = 12'd99;
            end
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 20) begin
                @(negedge clk);
                acc = para_ready;
                if (i == CN - 1 && n == 0) chk("no_run_during_load", psum_ready, 0);
                @(posedge clk);
                #1;
                cfg_start = 1'b0;
                n++;
            end
            if (!acc) begin
                chk("beat_accept_timeout", 0, 1);
                break;
            end
            exp_a[i] = pa(seed, i);
            exp_b[i] = pb(seed, i);
            if (poke && i == 50) begin
                chk("busy_start_err", cfg_err, 1);
                chk("busy_start_still_loading", para_ready, 1);
            end
        end
        para_valid = 1'b0;
    endtask

    task automatic run_pixels(input int n, input bit gaps, input bit poke_done);
        int sent = 0;
        int guard = 0;
        int ch;
        while (sent < n && guard < 100) begin
            if (gaps && (guard % 3 == 1)) begin
                psum_valid = 1'b0;
            end else begin
                psum_valid = 1'b1;
                ch = (sent * 37 + 5) % CN;
                sbq.push_back('{0, cyc, ch, exp_a[ch], exp_b[ch]});
                sent++;
            end
            tick();
            guard++;
        end
        // DONE cycle: psum_valid held high must not be admitted
        psum_valid = 1'b1;
        sbq.push_back('{1, cyc, 0, 0, 0});
        if (poke_done) begin
            cfg_start   = 1'b1;
            cfg_pix_num = 12'd5;
        end
        tick();
        cfg_start = 1'b0;
        chk("idle_after_done_busy", busy, 0);
        chk("idle_after_done_psum_ready", psum_ready, 0);
        if (poke_done) chk("done_start_err", cfg_err, 1);
        psum_valid = 1'b0;
    endtask

    initial begin
        int c0;
        // Reset with psum_valid high to confirm nothing leaks out
        rstn = 1'b0;
        psum_valid = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_para_ready", para_ready, 0);
        chk("rst_psum_ready", psum_ready, 0);
        chk("rst_valid", bn_data_in_valid, 0);
        chk("rst_done", layer_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rstn = 1'b1;
        psum_valid = 1'b0;
        for (int i = 0; i < CN; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        check_bank("rst");

        // Basic layer: 4 pixels, a=i+1, b=-i
        start_layer(4, c0);
        load(0, 1'b0, 1'b0);
        chk("run_entry_cycle", cyc, c0 + 129);
        chk("run_entry_psum_ready", psum_ready, 1);
        chk("basic_bn_a5", int'($signed(bn_a[5])), 6);
        chk("basic_bn_b5", int'($signed(bn_b[5])), -5);
        check_bank("basic");
        run_pixels(4, 1'b0, 1'b0);

        // Back-to-back: second layer starts at t+2 and fully replaces parameters
        start_layer(4, c0);
        load(1, 1'b0, 1'b0);
        check_bank("b2b");
        run_pixels(4, 1'b0, 1'b0);

        // Back-pressure on both sides plus cfg_start mid-LOAD and in DONE
        start_layer(4, c0);
        load(2, 1'b1, 1'b1);
        chk("bp_bn_a127", int'($signed(bn_a[127])), 181);
        chk("bp_bn_b127", int'($signed(bn_b[127])), 32640);
        check_bank("bp");
        run_pixels(4, 1'b1, 1'b1);

        // Zero-pixel layer: DONE straight after the last beat; start clears cfg_err
        psum_valid = 1'b1;
        start_layer(0, c0);
        load(0, 1'b0, 1'b0);
        sbq.push_back('{1, cyc, 0, 0, 0});
        tick();
        chk("zero_busy", busy, 0);
        psum_valid = 1'b0;
        check_bank("zero");

        // Reset in the middle of RUN after 2 of 4 pixels
        start_layer(4, c0);
        load(1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            psum_valid = 1'b1;
            sbq.push_back('{0, cyc, k, exp_a[k], exp_b[k]});
            tick();
        end
        psum_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        psum_valid = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_psum_ready", psum_ready, 0);
        chk("midrst_done", layer_done, 0);
        for (int i = 0; i < CN; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        check_bank("midrst");
        for (int k = 0; k < 6; k++) tick();
        psum_valid = 1'b0;
        chk("midrst_idle_busy", busy, 0);

        tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
